ulpi_reg_arb: RTL and testbench
===============================

Name: ulpi_reg_arb

Overview:
- Sequences ULPI PHY register reads and writes after the PHY reset sequence completes.
- Shares the single ULPI link between NUM_REQ internal requesters (config logic, debug, emulator core) using round-robin arbitration.
- Drives the link-side data byte and stp directly. The top level muxes o_data onto io_data when dir is low.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT, 255, max cycles waiting on nxt/dir before abandoning a transaction (8-bit counter).

Ports:
- i_clk  in  1  ULPI 60 MHz clock.
- i_rst  in  1  synchronous, active-high reset.
- i_phy_ready  in  1  high once the ULPI reset sequence has finished; no transaction starts while low.
- i_req  in  NUM_REQ  per-requester request, held until its o_done pulse.
- i_we  in  NUM_REQ  1 = write, 0 = read, per requester.
- i_addr  in  6*NUM_REQ  register address, requester k at bits [6k+5:6k].
- i_wdata  in  8*NUM_REQ  write data, requester k at bits [8k+7:8k].
- o_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_err  out  1  valid with o_done: 1 = aborted or timed out.
- o_rdata  out  8  read result, valid with o_done on reads; held until the next completion.
- o_busy  out  1  high from grant until done.
- i_dir  in  1  ULPI dir.
- i_nxt  in  1  ULPI nxt.
- i_data  in  8  ULPI data as sampled from io_data.
- o_data  out  8  byte to drive when dir = 0.
- o_stp  out  1  ULPI stp.

Behaviour:
- Reset values (i_rst = 1 at a clock edge):
  - state IDLE, o_data = 8'h00, o_stp = 0, o_done = 0, o_err = 0, o_rdata = 8'h00, o_busy = 0.
  - Round-robin pointer = 0.
  - Reset mid-transaction abandons it with no o_done and no stp.
- Arbitration:
  - In IDLE, when i_phy_ready = 1, i_dir = 0 and any i_req bit is set, grant the first requester at or after the pointer (wrapping at NUM_REQ).
  - Latch that requester's we/addr/wdata and set o_busy.
  - The pointer becomes granted index + 1 (mod NUM_REQ) at completion.
  - Requests arriving mid-transaction wait; i_req is not a one-shot.
- States:
  - IDLE: o_data = 00.
  - CMD:
    - o_data = {we ? 2'b10 : 2'b11, addr}.
    - Hold until i_nxt = 1 with i_dir = 0. Writes go to WDATA; reads go to RTURN.
    - i_dir = 1 before nxt means the PHY has taken the bus: drop o_data to 00 and go to ABORTWAIT.
  - WDATA:
    - o_data = wdata, held until i_nxt = 1, then go to WSTP.
    - i_dir = 1 goes to ABORTWAIT.
  - WSTP: o_stp = 1 and o_data = 00 for exactly one cycle, then DONE with err = 0.
  - RTURN: expect i_dir = 1 (turnaround cycle), then go to RDATA.
  - RDATA:
    - Capture i_data into o_rdata when i_dir = 1 and i_nxt = 0, then go to RDONE.
    - i_nxt = 1 in RDATA means an RX CMD/USB data collision: go to ABORTWAIT.
  - RDONE: wait for i_dir = 0 (turnaround back), then DONE with err = 0.
  - ABORTWAIT: wait for i_dir = 0, then return to IDLE and retry the same grant. The pointer is unchanged and there is no o_done.
  - DONE: pulse o_done[granted] with o_err for one cycle, clear o_busy, advance the pointer, go to IDLE.
- Timeout:
  - An 8-bit counter is cleared on every state change and increments in CMD, WDATA, RTURN, RDATA, RDONE and ABORTWAIT.
  - Reaching TIMEOUT → DONE with o_err = 1. No stp is issued on timeout.
- Link-side output rule: o_data is 00 whenever the state is not CMD/WDATA, and the block never asserts stp outside WSTP.
- i_phy_ready falling while busy has no effect on the transaction in progress; it only blocks new grants.
- Latency: an uncontended write with nxt returned the cycle after each byte completes in 5 cycles from request to o_done.

Test Plan:
- Single write, req0 addr 0x0A data 0x45, PHY asserts nxt 1 cycle after CMD and 1 cycle after data:
  - o_data sequence 8A, 45, then 00 with stp = 1 for one cycle.
  - o_done[0] = 1, o_err = 0.
- Single read, req1 addr 0x16:
  - o_data = D6 until nxt, then dir rises, the PHY drives 0x5A, dir falls.
  - o_rdata = 5A, o_done[1] = 1, o_err = 0, no stp.
- Both requesters asserted continuously for 4 transactions: grants alternate 0, 1, 0, 1; o_done never asserts for both requesters in the same cycle.
- Abort: PHY raises dir during CMD before nxt, holds 3 cycles, drops:
  - No o_done.
  - Same CMD byte is reissued after dir falls and completes normally.
- Timeout with TIMEOUT = 16: nxt is never asserted → o_done pulses with o_err = 1 exactly 16 cycles after entering CMD; o_stp stays 0.
- i_rst pulsed during WDATA: next cycle o_busy = 0, o_data = 00, o_stp = 0; a held request is re-granted after i_rst falls, provided i_phy_ready = 1.

Source files
------------

// File: rtl/ulpi_reg_arb.sv
// ULPI register access sequencer: round-robin arbitration between internal
// requesters, then TX CMD / data / stp on writes and turnaround/capture on reads.
module ulpi_reg_arb #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_phy_ready,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_we,
    input  logic [6*NUM_REQ-1:0] i_addr,
    input  logic [8*NUM_REQ-1:0] i_wdata,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_err,
    output logic [7:0]           o_rdata,
    output logic                 o_busy,
    input  logic                 i_dir,
    input  logic                 i_nxt,
    input  logic [7:0]           i_data,
    output logic [7:0]           o_data,
    output logic                 o_stp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WSTP,
        S_RTURN,
        S_RDATA,
        S_RDONE,
        S_ABORTWAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] ptr_q;
    logic             we_q;
    logic [5:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       cnt_q;
    logic             err_q;
    logic [7:0]       rdata_q;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic             sel_we;
    logic [5:0]       sel_addr;
    logic [7:0]       sel_wdata;
    logic             grant_now;
    logic             capture;
    logic             timeout_hit;
    logic             waiting;
    logic             tmo;

    assign tmo     = (cnt_q == 8'(TIMEOUT - 1));
    assign waiting = state_q inside {S_CMD, S_WDATA, S_RTURN, S_RDATA, S_RDONE, S_ABORTWAIT};

    // Round-robin pick: first pass looks at/after the pointer, second pass wraps to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_valid && i_req[IDX_W'(j)] && (IDX_W'(j) >= ptr_q)) begin
                arb_valid = 1'b1;
                arb_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_valid && i_req[IDX_W'(j)]) begin
                arb_valid = 1'b1;
                arb_idx   = IDX_W'(j);
            end
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == arb_idx) begin
                sel_we    = i_we[j];
                sel_addr  = i_addr[6*j +: 6];
                sel_wdata = i_wdata[8*j +: 8];
            end
        end
    end

    // Next-state logic for the link sequencer.
    always_comb begin
        state_d     = state_q;
        grant_now   = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    // Retry of an aborted grant: only needs the bus back.
                    if (!i_dir) state_d = S_CMD;
                end else if (i_phy_ready && !i_dir && arb_valid) begin
                    grant_now = 1'b1;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (i_dir)      state_d = S_ABORTWAIT;
                else if (i_nxt) state_d = we_q ? S_WDATA : S_RTURN;
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_WDATA: begin
                if (i_dir)      state_d = S_ABORTWAIT;
                else if (i_nxt) state_d = S_WSTP;
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_WSTP: state_d = S_DONE;
            S_RTURN: begin
                if (i_dir)      state_d = S_RDATA;
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_RDATA: begin
                if (i_nxt)      state_d = S_ABORTWAIT;
                else if (i_dir) begin state_d = S_RDONE; capture = 1'b1; end
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_RDONE: begin
                if (!i_dir)     state_d = S_DONE;
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_ABORTWAIT: begin
                if (!i_dir)     state_d = S_IDLE;
                else if (tmo)   begin state_d = S_DONE; timeout_hit = 1'b1; end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant bookkeeping, timeout counter and read capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;

            if (state_d != state_q) cnt_q <= '0;
            else if (waiting)       cnt_q <= cnt_q + 8'd1;

            if (grant_now) begin
                busy_q  <= 1'b1;
                grant_q <= arb_idx;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end

            if (state_d == S_DONE && state_q != S_DONE) err_q <= timeout_hit;

            if (capture) rdata_q <= i_data;

            if (state_q == S_DONE) begin
                busy_q <= 1'b0;
                if ({1'b0, grant_q} == (IDX_W + 1)'(NUM_REQ - 1)) ptr_q <= '0;
                else                                              ptr_q <= grant_q + IDX_W'(1);
            end
        end
    end

    // Link-side and requester-side outputs decoded from state.
    always_comb begin
        o_data = 8'h00;
        o_stp  = 1'b0;
        o_done = '0;
        o_err  = 1'b0;
        case (state_q)
            S_CMD:   if (!i_dir) o_data = {(we_q ? 2'b10 : 2'b11), addr_q};
            S_WDATA: if (!i_dir) o_data = wdata_q;
            S_WSTP:  o_stp = 1'b1;
            S_DONE: begin
                o_done[grant_q] = 1'b1;
                o_err           = err_q;
            end
            default: ;
        endcase
    end

    assign o_busy  = busy_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_ulpi_reg_arb.sv
// Directed bench for ulpi_reg_arb: write, read, alternation, abort, timeout, reset.
module tb_ulpi_reg_arb;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_phy_ready;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [11:0] i_addr;
    logic [15:0] i_wdata;
    logic [1:0]  o_done;
    logic        o_err;
    logic [7:0]  o_rdata;
    logic        o_busy;
    logic        i_dir;
    logic        i_nxt;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_stp;

    int n_checks = 0;
    int n_pass   = 0;

    ulpi_reg_arb #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_phy_ready (i_phy_ready),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_busy      (o_busy),
        .i_dir       (i_dir),
        .i_nxt       (i_nxt),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_stp       (o_stp)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g[4];
        int ng;
        logic saw_done;
        logic saw_stp;

        i_rst = 1'b1; i_phy_ready = 1'b0; i_req = '0; i_we = '0;
        i_addr = '0; i_wdata = '0; i_dir = 1'b0; i_nxt = 1'b0; i_data = '0;
        tick(); tick();
        check("rst_busy",  o_busy,  0);
        check("rst_data",  o_data,  8'h00);
        check("rst_stp",   o_stp,   0);
        check("rst_done",  o_done,  0);
        check("rst_err",   o_err,   0);
        check("rst_rdata", o_rdata, 8'h00);
        i_rst = 1'b0;

        // PHY not ready: request must not be granted.
        i_we[0] = 1'b1; i_addr[5:0] = 6'h0A; i_wdata[7:0] = 8'h45; i_req[0] = 1'b1;
        tick(); tick();
        check("notready_busy", o_busy, 0);
        check("notready_data", o_data, 8'h00);

        // Single write from requester 0.
        i_phy_ready = 1'b1;
        tick();
        check("wr_busy", o_busy, 1);
        check("wr_cmd",  o_data, 8'h8A);
        i_nxt = 1'b1;
        tick();
        check("wr_data",     o_data, 8'h45);
        check("wr_data_stp", o_stp,  0);
        tick();
        check("wr_stp_data", o_data, 8'h00);
        check("wr_stp",      o_stp,  1);
        i_nxt = 1'b0;
        tick();
        check("wr_done",     o_done, 2'b01);
        check("wr_err",      o_err,  0);
        check("wr_done_stp", o_stp,  0);
        i_req[0] = 1'b0;
        tick();
        check("wr_idle_done", o_done, 0);
        check("wr_idle_busy", o_busy, 0);

        // Single read from requester 1.
        i_we[1] = 1'b0; i_addr[11:6] = 6'h16; i_req[1] = 1'b1;
        tick();
        check("rd_cmd", o_data, 8'hD6);
        tick();
        check("rd_cmd_hold", o_data, 8'hD6);
        i_nxt = 1'b1;
        tick();
        check("rd_rturn_data", o_data, 8'h00);
        i_nxt = 1'b0; i_dir = 1'b1;
        tick();
        i_data = 8'h5A;
        tick();
        check("rd_rdata",    o_rdata, 8'h5A);
        check("rd_not_done", o_done,  0);
        i_dir = 1'b0; i_data = 8'h00;
        tick();
        check("rd_done", o_done, 2'b10);
        check("rd_err",  o_err,  0);
        check("rd_stp",  o_stp,  0);
        i_req[1] = 1'b0;
        tick();

        // Both requesters held: grants must alternate starting at 0.
        i_we = 2'b11; i_wdata[15:8] = 8'h33; i_nxt = 1'b1; i_req = 2'b11;
        g = '{default: -1};
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (o_done != 2'b00) begin
                check("alt_onehot", $countones(o_done), 1);
                g[ng] = o_done[1] ? 1 : 0;
                ng++;
                if (ng == 4) i_req = 2'b00;
            end
        end
        check("alt_count", ng, 4);
        for (int k = 0; k < 4; k++) check("alt_grant", g[k], k % 2);
        tick();
        i_nxt = 1'b0;

        // Abort: PHY takes the bus during CMD for 3 cycles.
        i_req[0] = 1'b1;
        tick();
        check("ab_cmd", o_data, 8'h8A);
        i_dir = 1'b1;
        #1;
        check("ab_gate", o_data, 8'h00);
        tick();
        check("ab_wait_data", o_data, 8'h00);
        check("ab_wait_busy", o_busy, 1);
        saw_done = (o_done != 0);
        tick();
        saw_done |= (o_done != 0);
        tick();
        saw_done |= (o_done != 0);
        i_dir = 1'b0;
        tick();
        saw_done |= (o_done != 0);
        check("ab_no_done", saw_done, 0);
        check("ab_idle_busy", o_busy, 1);
        tick();
        check("ab_reissue", o_data, 8'h8A);
        i_nxt = 1'b1;
        tick();
        check("ab_wdata", o_data, 8'h45);
        tick();
        check("ab_stp", o_stp, 1);
        i_nxt = 1'b0;
        tick();
        check("ab_done", o_done, 2'b01);
        check("ab_err",  o_err,  0);
        i_req[0] = 1'b0;
        tick();

        // Timeout: nxt never arrives; done+err 16 cycles after entering CMD.
        i_req[0] = 1'b1;
        tick();
        check("to_cmd", o_data, 8'h8A);
        saw_done = 1'b0;
        saw_stp  = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            saw_stp |= o_stp;
            if (k < 16) saw_done |= (o_done != 0);
        end
        check("to_early_done", saw_done, 0);
        check("to_done", o_done, 2'b01);
        check("to_err",  o_err,  1);
        check("to_stp",  saw_stp, 0);
        i_req[0] = 1'b0;
        tick();
        check("to_err_clear", o_err, 0);
        check("rdata_held", o_rdata, 8'h5A);

        // Reset during WDATA, request held: re-granted afterwards.
        i_req[0] = 1'b1;
        tick();
        i_nxt = 1'b1;
        tick();
        check("rs_wdata", o_data, 8'h45);
        i_nxt = 1'b0; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rs_busy", o_busy, 0);
        check("rs_data", o_data, 8'h00);
        check("rs_stp",  o_stp,  0);
        check("rs_done", o_done, 0);
        tick();
        check("rs_regrant_busy", o_busy, 1);
        check("rs_regrant_cmd",  o_data, 8'h8A);
        i_nxt = 1'b1;
        tick();
        tick();
        check("rs_stp_again", o_stp, 1);
        i_nxt = 1'b0;
        tick();
        check("rs_done_again", o_done, 2'b01);
        i_req[0] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
